// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative radix-2 multiply/divide unit.
//
// Performs one shift-add (multiply) or restoring shift-subtract (divide)
// step per clock. It uses a single private adder that is shared between
// the two modes. Signed operations work on operand magnitudes. The sign
// of each result is applied in a final fix-up cycle.
//
// Ports:
//   CLK       rising-edge clock
//   Reset     asynchronous, active-low reset
//   Start     operation request, sampled only while idle
//   Op        00 UMUL, 01 SMUL, 10 UDIV, 11 SDIV (latched with Start)
//   OperandA  multiplicand / dividend (latched with Start)
//   OperandB  multiplier / divisor (latched with Start)
//   Busy      high while an operation is in progress
//   Done      one-cycle pulse when the results become valid
//   ResultLo  MUL: product[WIDTH-1:0]      DIV: quotient
//   ResultHi  MUL: product[2*WIDTH-1:WIDTH] DIV: remainder
//   DivZero   set with Done for a divide by zero; cleared by the next Start
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             DivZero
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] OP_UMUL = 2'b00;
  localparam logic [1:0] OP_SMUL = 2'b01;
  localparam logic [1:0] OP_UDIV = 2'b10;
  localparam logic [1:0] OP_SDIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              is_div_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  hi_q;      // partial product high half / partial remainder
  logic [WIDTH-1:0]  lo_q;      // multiplier shift register / quotient shift register
  logic [WIDTH-1:0]  addend_q;  // multiplicand or divisor magnitude
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              dz_q;

  logic signed [WIDTH-1:0] opa_s;
  logic signed [WIDTH-1:0] opb_s;
  logic                    is_signed;
  logic                    div_by_zero;

  logic [WIDTH+1:0] add_a;
  logic [WIDTH+1:0] add_b;
  logic [WIDTH+1:0] add_cin;
  logic [WIDTH+1:0] add_sum;
  logic             div_ge;

  // Two's-complement magnitude. The most negative value maps to 2^(WIDTH-1),
  // which is still representable as an unsigned WIDTH-bit magnitude.
  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = (v < 0) ? -v : v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v,
                                             input logic            en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v,
                                                input logic              en);
    return en ? -v : v;
  endfunction

  assign opa_s       = OperandA;
  assign opb_s       = OperandB;
  assign is_signed   = Op[0];
  assign div_by_zero = Op[1] && (OperandB == '0);

  // Shared adder, WIDTH+2 bits wide.
  // Multiply: hi + (lo[0] ? addend : 0). The top bit is always 0 and bit
  //   WIDTH is the carry that shifts into hi.
  // Divide: {hi, lo msb} - addend. The top bit is the borrow, so a 0 there
  //   means the shifted remainder is at least the divisor.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = '0;
    if (is_div_q) begin
      add_a   = {1'b0, hi_q, lo_q[WIDTH-1]};
      add_b   = ~{2'b00, addend_q};
      add_cin = {{(WIDTH+1){1'b0}}, 1'b1};
    end else begin
      add_a = {2'b00, hi_q};
      add_b = lo_q[0] ? {2'b00, addend_q} : '0;
    end
    add_sum = add_a + add_b + add_cin;
    div_ge  = ~add_sum[WIDTH+1];
  end

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and Busy
  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = div_by_zero ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        Busy = 1'b1;
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        Busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      is_div_q  <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      addend_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
      ResultLo  <= '0;
      ResultHi  <= '0;
    end else begin
      Done <= (state_q == S_FIX);
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            is_div_q <= Op[1];
            cnt_q    <= CNT_LOAD;
            DivZero  <= 1'b0;
            if (div_by_zero) begin
              // The fix-up cycle passes these through unchanged: an all-ones
              // quotient, and the dividend returned as the remainder.
              hi_q      <= OperandA;
              lo_q      <= '1;
              addend_q  <= OperandB;
              neg_res_q <= 1'b0;
              neg_rem_q <= 1'b0;
              dz_q      <= 1'b1;
            end else begin
              hi_q      <= '0;
              lo_q      <= is_signed ? abs_w(opa_s) : OperandA;
              addend_q  <= is_signed ? abs_w(opb_s) : OperandB;
              neg_res_q <= is_signed && (opa_s[WIDTH-1] ^ opb_s[WIDTH-1]);
              neg_rem_q <= (Op == OP_SDIV) && opa_s[WIDTH-1];
              dz_q      <= 1'b0;
            end
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (is_div_q) begin
            hi_q <= div_ge ? add_sum[WIDTH-1:0] : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            lo_q <= {lo_q[WIDTH-2:0], div_ge};
          end else begin
            hi_q <= add_sum[WIDTH:1];
            lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          DivZero <= dz_q;
          if (is_div_q) begin
            ResultLo <= neg_w(lo_q, neg_res_q);
            ResultHi <= neg_w(hi_q, neg_rem_q);
          end else begin
            {ResultHi, ResultLo} <= neg_2w({hi_q, lo_q}, neg_res_q);
          end
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  // Op encodings kept for readability of the decode above.
  logic unused_ops;
  assign unused_ops = ^{OP_UMUL, OP_SMUL, OP_UDIV};

endmodule
